// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decoder
// Description : Debounces a multiplexed active-low 7-segment bus, decodes each
//               stable pattern to a hex value and reports changes per digit.
//               Define SEG_DECODE_ERR_CNT_EN to add the err_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [1:0]  dig_sel,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  out_digit,
  output logic [3:0]  out_number,
  output logic        out_bad,
  output logic [15:0] digits
`ifdef SEG_DECODE_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [6:0] c_BLANK_N = 7'h7F;
  localparam logic [3:0] c_STABLE  = 4'(STABLE_CYCLES);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [1:0]      samp_dig_q;
  logic [6:0]      samp_seg_q;
  logic [6:0]      res_seg_q;
  logic [3:0][6:0] last_seg_q;
  logic [3:0]      last_vld_q;

  logic [3:0]      num_d;
  logic            bad_d;
  logic            w_changed;
  logic            w_blank;
  logic            w_dup;

  assign w_changed = {dig_sel, seg_n} != {samp_dig_q, samp_seg_q};
  assign w_blank   = samp_seg_q == c_BLANK_N;
  assign w_dup     = last_vld_q[samp_dig_q] && (last_seg_q[samp_dig_q] == samp_seg_q);

  always_comb begin
    num_d = 4'h0;
    bad_d = 1'b0;
    case (~samp_seg_q)
      7'h3F: num_d = 4'h0;
      7'h06: num_d = 4'h1;
      7'h5B: num_d = 4'h2;
      7'h4F: num_d = 4'h3;
      7'h66: num_d = 4'h4;
      7'h6D: num_d = 4'h5;
      7'h7D: num_d = 4'h6;
      7'h07: num_d = 4'h7;
      7'h7F: num_d = 4'h8;
      7'h6F: num_d = 4'h9;
      7'h5F: num_d = 4'hA;
      7'h7C: num_d = 4'hB;
      7'h58: num_d = 4'hC;
      7'h5E: num_d = 4'hD;
      7'h79: num_d = 4'hE;
      7'h71: num_d = 4'hF;
      default: bad_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      samp_dig_q <= 2'd0;
      samp_seg_q <= c_BLANK_N;
      res_seg_q  <= c_BLANK_N;
      last_seg_q <= '0;
      last_vld_q <= 4'b0000;
      out_valid  <= 1'b0;
      out_digit  <= 2'd0;
      out_number <= 4'd0;
      out_bad    <= 1'b0;
      digits     <= 16'h0000;
    end else begin
      samp_dig_q <= dig_sel;
      samp_seg_q <= seg_n;
      case (state_q)
        S_IDLE, S_SETTLE: begin
          // The sample register has now held one value for c_STABLE edges.
          if (state_q == S_SETTLE && cnt_q == c_STABLE) begin
            cnt_q <= 4'd0;
            if (w_blank || w_dup) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_HOLD;
              out_valid  <= 1'b1;
              out_digit  <= samp_dig_q;
              out_number <= num_d;
              out_bad    <= bad_d;
              res_seg_q  <= samp_seg_q;
            end
          end else if (w_changed) begin
            state_q <= S_SETTLE;
            cnt_q   <= 4'd1;
          end else if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q                <= S_IDLE;
            cnt_q                  <= 4'd0;
            out_valid              <= 1'b0;
            last_seg_q[out_digit]  <= res_seg_q;
            last_vld_q[out_digit]  <= 1'b1;
            if (!out_bad) begin
              digits[{out_digit, 2'b00} +: 4] <= out_number;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SEG_DECODE_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (state_q == S_HOLD && out_ready && out_bad && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  // Error counter omitted in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_decoder.sv
`default_nettype none
// Bench for seven_seg_decoder: directed scenarios with literal expectations,
// then random bus activity checked every cycle against an event-level model.
module tb_seven_seg_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h5F, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [1:0]  dig_sel;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_digit;
  logic [3:0]  out_number;
  logic        out_bad;
  logic [15:0] digits;
`ifdef SEG_DECODE_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  seven_seg_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .dig_sel    (dig_sel),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digit  (out_digit),
    .out_number (out_number),
    .out_bad    (out_bad),
    .digits     (digits)
`ifdef SEG_DECODE_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: a candidate run starts at the edge where the bus value changes while
  // nothing is pending; it is judged STABLE edges later.
  logic [8:0] m_prev;
  bit         m_armed;
  int         m_start;
  int         m_edge = 0;
  bit         m_pend;
  logic [1:0] m_dig;
  logic [3:0] m_num;
  bit         m_bad;
  logic [6:0] m_seg;
  logic [6:0] m_last_seg [4];
  bit         m_last_vld [4];
  logic [3:0] m_digits [4];
  int         m_err;

  task automatic decode(input logic [6:0] pat_n, output logic [3:0] num, output bit bad);
    num = 4'd0;
    bad = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (CODES[i] == ~pat_n) begin
        num = 4'(i);
        bad = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    logic [8:0] s;
    s = {dig_sel, seg_n};
    m_edge++;
    if (!rst_n) begin
      m_prev  = {2'b00, 7'h7F};
      m_armed = 0;
      m_pend  = 0;
      m_err   = 0;
      for (int i = 0; i < 4; i++) begin
        m_last_vld[i] = 0;
        m_digits[i]   = 4'd0;
      end
      return;
    end
    if (m_pend) begin
      if (out_ready) begin
        m_pend = 0;
        m_armed = 0;
        m_last_seg[m_dig] = m_seg;
        m_last_vld[m_dig] = 1;
        if (!m_bad) m_digits[m_dig] = m_num;
        else if (m_err < 255) m_err++;
      end
    end else if (m_armed && (m_edge - m_start) == STABLE) begin
      m_armed = 0;
      if (m_prev[6:0] != 7'h7F &&
          !(m_last_vld[m_prev[8:7]] && m_last_seg[m_prev[8:7]] == m_prev[6:0])) begin
        m_pend = 1;
        m_dig  = m_prev[8:7];
        m_seg  = m_prev[6:0];
        decode(m_seg, m_num, m_bad);
      end
    end else if (s != m_prev) begin
      m_armed = 1;
      m_start = m_edge;
    end
    m_prev = s;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_pend});
    if (m_pend) begin
      check("out_digit",  {30'd0, out_digit},  {30'd0, m_dig});
      check("out_number", {28'd0, out_number}, {28'd0, m_num});
      check("out_bad",    {31'd0, out_bad},    {31'd0, m_bad});
    end
    check("digits", {16'd0, digits},
          {16'd0, m_digits[3], m_digits[2], m_digits[1], m_digits[0]});
`ifdef SEG_DECODE_ERR_CNT_EN
    check("err_count", {24'd0, err_count}, m_err);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int         seen;
    int         got_n [$];
    int         exp_n [4]     = '{1, 6, 15, 0};
    logic [6:0] scan_code [4] = '{7'h06, 7'h7D, 7'h71, 7'h3F};
    logic [6:0] code;

    rst_n = 1'b0; seg_n = 7'h7F; dig_sel = 2'd0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_digits", {16'd0, digits},    32'd0);
    rst_n = 1'b1;

    // Digit 2 shows "2", accepted immediately.
    dig_sel = 2'd2; seg_n = ~7'h5B; out_ready = 1'b1;
    repeat (4) tick();
    check("t1_early_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_valid",  {31'd0, out_valid},   32'd1);
    check("t1_number", {28'd0, out_number},  32'd2);
    tick();
    check("t1_after_valid", {31'd0, out_valid},  32'd0);
    check("t1_digit2",      {28'd0, digits[11:8]}, 32'd2);

    // Short glitch of "9" is superseded by "3".
    dig_sel = 2'd0; seg_n = ~7'h6F;
    repeat (2) tick();
    seg_n = ~7'h4F;
    repeat (4) begin
      tick();
      check("t2_no_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    check("t2_valid",  {31'd0, out_valid},  32'd1);
    check("t2_number", {28'd0, out_number}, 32'd3);
    tick();

    // Three full scans; only the first produces results.
    for (int sc = 0; sc < 3; sc++) begin
      seen = 0;
      for (int d = 0; d < 4; d++) begin
        dig_sel = 2'(d); seg_n = ~scan_code[d];
        repeat (8) begin
          tick();
          if (out_valid) begin
            seen++;
            got_n.push_back(int'(out_number));
          end
        end
      end
      check("scan_count", seen, (sc == 0) ? 32'd4 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_n.size()) check("scan_number", got_n[i], exp_n[i]);
      else check("scan_number_missing", 32'hFFFF_FFFF, exp_n[i]);
    end

    // Blank bus never reports.
    dig_sel = 2'd3; seg_n = 7'h7F;
    repeat (10) begin
      tick();
      check("blank_valid", {31'd0, out_valid}, 32'd0);
    end

    // Illegal code 0x01 on digit 1.
    dig_sel = 2'd1; seg_n = ~7'h01;
    repeat (5) tick();
    check("bad_valid",  {31'd0, out_valid},  32'd1);
    check("bad_flag",   {31'd0, out_bad},    32'd1);
    check("bad_number", {28'd0, out_number}, 32'd0);
    tick();
    check("bad_digits", {16'd0, digits}, 32'h0F61);
`ifdef SEG_DECODE_ERR_CNT_EN
    check("bad_errcnt", {24'd0, err_count}, 32'd1);
`endif

    // Result held without ready, inputs wiggling, then reset drops it.
    out_ready = 1'b0; dig_sel = 2'd0; seg_n = ~7'h5B;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      seg_n = 7'($urandom); dig_sel = 2'($urandom);
      tick();
      check("hold_valid",  {31'd0, out_valid},  32'd1);
      check("hold_number", {28'd0, out_number}, 32'd2);
      check("hold_digit",  {30'd0, out_digit},  32'd0);
    end
    rst_n = 1'b0;
    tick();
    check("hold_rst_valid",  {31'd0, out_valid}, 32'd0);
    check("hold_rst_digits", {16'd0, digits},    32'd0);
    rst_n = 1'b1;

    // Random bus activity.
    for (int seg = 0; seg < 400; seg++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)       code = CODES[$urandom_range(0, 15)];
      else if (r == 6) code = 7'h00;
      else             code = 7'($urandom);
      dig_sel = 2'($urandom_range(0, 3));
      seg_n   = ~code;
      repeat ($urandom_range(1, 10)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        rst_n     = ($urandom_range(0, 199) != 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
